// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer and the
// pipeline registers it drives.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctrl_t;

  // Instruction word a flushed pipeline register loads (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam ctrl_t CTRL_FREEZE = '{default: 1'b0};
  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                    ex_mem_write: 1'b1, mem_wb_write: 1'b1,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                    ex_mem_write: 1'b1, mem_wb_write: 1'b1,
                                    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1};
  localparam ctrl_t CTRL_HAZARD = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
                                    ex_mem_write: 1'b1, mem_wb_write: 1'b1,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0};
  localparam ctrl_t CTRL_IMEM   = '{pc_write: 1'b0, if_id_write: 1'b1, id_ex_write: 1'b1,
                                    ex_mem_write: 1'b1, mem_wb_write: 1'b1,
                                    if_id_flush: 1'b1, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: arbitrates memory waits, taken branches and
// load-use hazards into pipeline-register write enables and flushes.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  input  logic             imem_busy,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             timeout_err,
  output state_t           state
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  // wait_cnt counts busy cycles spent in MEM_WAIT; the MEM_TIMEOUT-th one halts
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  logic              timeout_err_n;
  ctrl_t             ctrl;
  logic              branch_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_cnt_n;
      timeout_err <= timeout_err_n;
    end
  end

  always_comb begin
    state_n       = state;
    wait_cnt_n    = wait_cnt;
    timeout_err_n = timeout_err;
    case (state)
      RUN: begin
        wait_cnt_n = '0;
        if (dmem_busy) state_n = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!dmem_busy) begin
          state_n    = RUN;
          wait_cnt_n = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_n       = HALT;
          timeout_err_n = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      HALT:    state_n = HALT;
      default: state_n = RUN;
    endcase
  end

  // Mealy control: registered state plus this cycle's requests, no added latency
  always_comb begin
    ctrl       = CTRL_FREEZE;
    branch_row = 1'b0;
    if (!rst && (state != HALT)) begin
      if (dmem_busy) begin
        ctrl = CTRL_FREEZE;
      end else if (branch_taken) begin
        ctrl       = CTRL_BRANCH;
        branch_row = 1'b1;
      end else if (hazard_detected) begin
        ctrl = CTRL_HAZARD;
      end else if (imem_busy) begin
        ctrl = CTRL_IMEM;
      end else begin
        ctrl = CTRL_RUN;
      end
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign id_ex_write  = ctrl.id_ex_write;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign mem_wb_write = ctrl.mem_wb_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;

  logic cnt_zero;
  logic stall_inc;

  assign cnt_zero  = rst | cnt_clr;
  assign stall_inc = !ctrl.pc_write && (state != HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (cnt_zero),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (cnt_zero),
    .inc   (branch_row),
    .count (flush_count)
  );

endmodule
